button_reader: RTL
==================

Name: button_reader

Overview:
Input-side companion to the board LED drivers. It reads one raw push-button pin, synchronises and debounces it, and classifies each press.
It emits single-cycle press, release and long-press events, a stable level and a wrapping press counter for downstream logic (mode select, VGA pattern stepping).
It runs in the 25.175 MHz PLL clock domain.

Parameters:
DEBOUNCE_CYCLES, 251750, cycles the synchronised input must be stable before a level change is accepted (10 ms at 25.175 MHz); legal range >= 2.
LONG_CYCLES, 25175000, cycles of accepted-pressed hold, counted from the press_pulse cycle, before long_pulse fires (1 s); must be > DEBOUNCE_CYCLES.
ACTIVE_LOW, 1, 1: btn_raw = 0 means pressed (BTN_N style); 0: btn_raw = 1 means pressed.

Ports:
clk  input  1  25.175 MHz PLL clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
btn_raw  input  1  asynchronous button pin, polarity per ACTIVE_LOW.
btn_level  output  1  debounced level, 1 = pressed.
press_pulse  output  1  one-cycle strobe on an accepted press.
release_pulse  output  1  one-cycle strobe on an accepted release.
long_pulse  output  1  one-cycle strobe, at most once per press, when the hold reaches LONG_CYCLES.
press_count  output  8  count of accepted presses, wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. No other clocks; no async reset.
- Input synchroniser:
  - btn_raw passes through a 2-flop synchroniser, then polarity normalisation: p = sync XOR ACTIVE_LOW, 1 = pressed.
  - Synchroniser flops reset to the released value.
- Counters:
  - deb_cnt and hold_cnt are unsigned, width $clog2 of the maximum of their parameter + 1.
  - Both saturate and never wrap.
- State machine, 4 states; reset to IDLE:
  - IDLE (stable released):
    - p = 1 -> PRESS_WAIT, deb_cnt <= 1.
  - PRESS_WAIT:
    - p = 0 -> IDLE, deb_cnt <= 0 (glitch rejected, no pulse).
    - p = 1 and deb_cnt == DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse = 1 next cycle; btn_level <= 1; press_count += 1; hold_cnt <= 0.
    - Otherwise deb_cnt += 1.
  - PRESSED:
    - hold_cnt increments while below LONG_CYCLES.
    - The cycle hold_cnt reaches LONG_CYCLES, long_pulse = 1 for exactly one cycle. It does not repeat for this press.
    - p = 0 -> RELEASE_WAIT, deb_cnt <= 1. hold_cnt keeps counting in RELEASE_WAIT, so a bounce does not reset the long-press timer.
  - RELEASE_WAIT:
    - p = 1 -> PRESSED, deb_cnt <= 0 (bounce rejected, no pulses, long_pulse state preserved).
    - p = 0 and deb_cnt == DEBOUNCE_CYCLES-1 -> IDLE; release_pulse = 1 next cycle; btn_level <= 0.
- Latency:
  - With btn_raw changing cleanly at edge N, the event pulse and the btn_level change appear at edge N + 2 + DEBOUNCE_CYCLES.
  - Budget: 2 synchroniser cycles + DEBOUNCE_CYCLES stability cycles.
- Output registering:
  - All outputs are registered.
  - At most one of press_pulse / release_pulse / long_pulse is high in any cycle.
  - If long_pulse and a release acceptance would coincide, long_pulse is issued first and release_pulse follows at the next acceptance. The FSM accepts the release only after long_pulse has been issued.
- Reset values: btn_level = 0, press_pulse = 0, release_pulse = 0, long_pulse = 0, press_count = 0, state = IDLE, counters = 0.
- Reset mid-operation:
  - A reset during any state (including a held press) returns to IDLE with no pulses.
  - A button still held after reset is re-accepted as a new press after the full debounce latency.
- press_count:
  - Increments only on press_pulse.
  - 255 + 1 = 0, with no flag.

Test Plan:
Run the bench with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
1. Reset held 3 cycles, btn_raw = 1 -> all outputs 0, press_count = 0, no pulses for 50 cycles.
2. btn_raw 1->0 at edge 10, held low -> press_pulse high only at edge 16; btn_level = 1 from 16; press_count = 1.
3. Bounce btn_raw low for 3 cycles, then high, repeated 5 times -> no press_pulse; press_count stays 0; btn_level stays 0.
4. Press held 40 cycles after acceptance -> long_pulse exactly once, 20 cycles after press_pulse. Release -> release_pulse 6 cycles after btn_raw returns to 1; btn_level = 0.
5. Release bounce while pressed (btn_raw high 2 cycles, then low) -> no release_pulse, btn_level stays 1, long_pulse timing unchanged.
6. 257 clean press/release cycles -> press_count = 1 after wrap. Assert rst while pressed -> outputs 0; re-press accepted 6 cycles after rst deasserts.

Source files
------------

// File: rtl/button_reader.sv
// Purpose : synchronise, debounce and classify one raw push-button pin into level/press/release/long-press events.
// Latency : a clean btn_raw change is seen on btn_level and its event pulse 2 + DEBOUNCE_CYCLES cycles later.
// Backpressure: none; event outputs are single-cycle strobes that downstream logic must sample when they fire.
//
// Ports:
//   clk           - 25.175 MHz PLL clock, all logic on the rising edge
//   rst           - synchronous, active-high reset
//   btn_raw       - asynchronous button pin, pressed level chosen by ACTIVE_LOW
//   btn_level     - debounced level, 1 = pressed
//   press_pulse   - one-cycle strobe on an accepted press
//   release_pulse - one-cycle strobe on an accepted release
//   long_pulse    - one-cycle strobe, at most once per press, when the hold reaches LONG_CYCLES
//   press_count   - count of accepted presses, wraps 255 -> 0
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 251750,
    parameter int LONG_CYCLES     = 25175000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser. Reset loads the released pin level so that
    // a reset never manufactures a phantom press.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {2{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // Normalised pin: 1 = pressed regardless of board polarity.
    assign p = sync_q[1] ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // FSM + counters
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [DEB_W-1:0]    deb_q, deb_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                level_d, press_d, release_d, long_d;
    logic [7:0]          count_d;
    logic                hold_running;
    logic                long_due;

    // The hold timer runs through RELEASE_WAIT too, so a release bounce
    // does not disturb long-press timing.
    assign hold_running = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign long_due     = hold_running && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        count_d   = press_count;

        // Saturating hold timer; the single LONG-1 -> LONG step is the
        // only moment long_pulse can fire, which makes it once per press.
        if (hold_running && (hold_q < HOLD_MAX)) begin
            hold_d = hold_q + HOLD_ONE;
        end
        long_d = long_due;

        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = PRESS_WAIT;
                    deb_d   = DEB_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!p) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = PRESSED;
                    deb_d   = '0;
                    hold_d  = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = press_count + 8'd1;
                end else begin
                    deb_d = deb_q + DEB_ONE;
                end
            end

            PRESSED: begin
                if (!p) begin
                    state_d = RELEASE_WAIT;
                    deb_d   = DEB_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (p) begin
                    state_d = PRESSED;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    // A release that would land on the long_pulse cycle
                    // waits one cycle (deb_cnt parked at its limit) so the
                    // two strobes never overlap.
                    if (!long_due) begin
                        state_d   = IDLE;
                        deb_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end
                end else begin
                    deb_d = deb_q + DEB_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                deb_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            deb_q         <= '0;
            hold_q        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state_q       <= state_d;
            deb_q         <= deb_d;
            hold_q        <= hold_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            press_count   <= count_d;
        end
    end

endmodule
